int_ctrl: RTL and testbench

- Parametrised vectored interrupt controller that replaces the hard-wired external/timer interrupt logic of the 8-bit CPU core.
- Collects NUM_SRC sources, each edge- or level-sensitive, and masks them with a global and per-source enable.
- Selects the highest-priority source and presents a request plus vector address to the CPU.
- Tracks in-service state through an acknowledge / end-of-interrupt handshake.

---
 rtl/int_ctrl.sv | 150 +++++++++++++++
 tb/tb_int_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge/level sources, priority arbitration, ack/EOI service tracking.
// Optional nested servicing is enabled by defining INT_CTRL_NESTING_EN.
module int_ctrl #(
   parameter int unsigned          NUM_SRC    = 4,
   parameter int unsigned          ADDR_W     = 12,
   parameter logic [ADDR_W-1:0]    VEC_BASE   = 12'h010,
   parameter int unsigned          VEC_STRIDE = 16,
   parameter int unsigned          ID_W       = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic [NUM_SRC-1:0] edge_sel,
   input  logic               gie,
   input  logic [NUM_SRC-1:0] ie,
   input  logic [NUM_SRC-1:0] clr_pend,
   input  logic               irq_ack,
   input  logic               eoi,
   output logic               irq_req,
   output logic [ADDR_W-1:0]  irq_vec,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] in_service,
   output logic [NUM_SRC-1:0] overflow
);

   typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

   state_t             state, state_n;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] edge_det;
   logic [NUM_SRC-1:0] pend_n;
   logic [NUM_SRC-1:0] ovf_n;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] req_mask;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] isr_n;
   logic               ack_take;
   logic               any_elig;
   logic               found;
   logic [ID_W-1:0]    win_id;
   logic [ADDR_W-1:0]  win_vec;
   logic [ID_W-1:0]    id_n;
   logic [ADDR_W-1:0]  vec_n;
`ifdef INT_CTRL_NESTING_EN
   logic [NUM_SRC-1:0] isr_low;
   logic [NUM_SRC-1:0] isr_below;
`endif

   // Pending/overflow update; a new edge overrides any clear in the same cycle.
   always_comb begin
      edge_det = src_in & ~src_q;
      req_mask = NUM_SRC'(1) << irq_id;
      ack_take = irq_ack && (state == REQUEST);
      ack_clr  = ack_take ? req_mask : '0;
      pend_n   = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (edge_sel[i])
            pend_n[i] = edge_det[i] | (pending[i] & ~(clr_pend[i] | ack_clr[i]));
         else
            pend_n[i] = src_in[i];
      end
      ovf_n = overflow | (edge_sel & edge_det & pending);
   end

   always_comb begin
      elig     = gie ? (pending & ie) : '0;
      any_elig = |elig;
      win_id   = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (elig[i] && !found) begin
            win_id = ID_W'(i);
            found  = 1'b1;
         end
      end
      win_vec = VEC_BASE + ADDR_W'(32'(win_id) * VEC_STRIDE);
`ifdef INT_CTRL_NESTING_EN
      isr_low   = in_service & (~in_service + NUM_SRC'(1));
      isr_below = isr_low - NUM_SRC'(1);
`endif
   end

   always_comb begin
      state_n = state;
      id_n    = irq_id;
      vec_n   = irq_vec;
      isr_n   = in_service;
      case (state)
         IDLE: begin
            if (any_elig) begin
               state_n = REQUEST;
               id_n    = win_id;
               vec_n   = win_vec;
            end
         end
         REQUEST: begin
            if (ack_take) begin
               isr_n = in_service | req_mask;
`ifdef INT_CTRL_NESTING_EN
               if (eoi)
                  isr_n = isr_n & (isr_n - NUM_SRC'(1));
`endif
               state_n = (isr_n == '0) ? IDLE : SERVICE;
            end else if ((elig & req_mask) == '0) begin
               // Withdrawn nested request falls back to the handler still in service.
               state_n = (in_service == '0) ? IDLE : SERVICE;
            end
         end
         SERVICE: begin
            if (eoi) begin
               isr_n = in_service & (in_service - NUM_SRC'(1));
               if (isr_n == '0)
                  state_n = IDLE;
            end
`ifdef INT_CTRL_NESTING_EN
            else if ((elig & isr_below) != '0) begin
               state_n = REQUEST;
               id_n    = win_id;
               vec_n   = win_vec;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src_q      <= '1;
         pending    <= '0;
         overflow   <= '0;
         in_service <= '0;
         irq_id     <= '0;
         irq_vec    <= VEC_BASE;
      end else begin
         state      <= state_n;
         src_q      <= src_in;
         pending    <= pend_n;
         overflow   <= ovf_n;
         in_service <= isr_n;
         irq_id     <= id_n;
         irq_vec    <= vec_n;
      end
   end

   assign irq_req = (state == REQUEST);

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: a cycle-level reference model predicts outputs after every edge,
// a negedge monitor pops and compares. Follows INT_CTRL_NESTING_EN when defined.
module tb_int_ctrl;

`ifdef INT_CTRL_NESTING_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src_in, edge_sel, ie, clr_pend;
   logic       gie, irq_ack, eoi;
   logic       irq_req;
   logic [11:0] irq_vec;
   logic [2:0] irq_id;
   logic [3:0] pending, in_service, overflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   int_ctrl #(
      .NUM_SRC(4), .ADDR_W(12), .VEC_BASE(12'h010), .VEC_STRIDE(16), .ID_W(3)
   ) dut (
      .clk(clk), .rst(rst), .src_in(src_in), .edge_sel(edge_sel), .gie(gie), .ie(ie),
      .clr_pend(clr_pend), .irq_ack(irq_ack), .eoi(eoi), .irq_req(irq_req),
      .irq_vec(irq_vec), .irq_id(irq_id), .pending(pending), .in_service(in_service),
      .overflow(overflow)
   );

   typedef struct {
      bit         req;
      bit         chk_idv;
      logic [2:0] id;
      logic [11:0] vec;
      logic [3:0] pend;
      logic [3:0] isr;
      logic [3:0] ovf;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   bit [3:0] m_srcq, m_pend, m_ovf, m_isr;
   bit       m_req;
   int       m_id;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input bit [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return 4;
   endfunction

   task automatic model_step();
      bit [3:0] np, el;
      bit       ack, rise;
      int       lo_el;
      exp_t     e;
      if (rst) begin
         m_srcq = '1; m_pend = '0; m_ovf = '0; m_isr = '0; m_req = 0; m_id = 0;
      end else begin
         ack = irq_ack && m_req;
         for (int i = 0; i < 4; i++) el[i] = gie && ie[i] && m_pend[i];
         for (int i = 0; i < 4; i++) begin
            if (edge_sel[i]) begin
               rise = src_in[i] && !m_srcq[i];
               if (rise && m_pend[i]) m_ovf[i] = 1'b1;
               if (rise) np[i] = 1'b1;
               else if (clr_pend[i] || (ack && m_id == i)) np[i] = 1'b0;
               else np[i] = m_pend[i];
            end else begin
               np[i] = src_in[i];
            end
         end
         lo_el = lowest(el);
         if (m_req) begin
            if (ack) begin
               m_isr[m_id] = 1'b1;
               if (NEST && eoi) m_isr[lowest(m_isr)] = 1'b0;
               m_req = 0;
            end else if (!el[m_id]) begin
               m_req = 0;
            end
         end else if (m_isr == 0) begin
            if (lo_el < 4) begin m_req = 1; m_id = lo_el; end
         end else if (eoi) begin
            m_isr[lowest(m_isr)] = 1'b0;
         end else if (NEST && lo_el < lowest(m_isr)) begin
            m_req = 1; m_id = lo_el;
         end
         m_srcq = src_in;
         m_pend = np;
      end
      e.req = m_req; e.chk_idv = m_req || rst;
      e.id = 3'(m_id); e.vec = 12'h010 + 12'(m_id * 16);
      e.pend = m_pend; e.isr = m_isr; e.ovf = m_ovf;
      sb.push_back(e);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("irq_req", int'(irq_req), int'(e.req));
         chk("pending", int'(pending), int'(e.pend));
         chk("in_service", int'(in_service), int'(e.isr));
         chk("overflow", int'(overflow), int'(e.ovf));
         if (e.chk_idv) begin
            chk("irq_id", int'(irq_id), int'(e.id));
            chk("irq_vec", int'(irq_vec), int'(e.vec));
         end
      end
   end

   task automatic pulse_ack(); irq_ack = 1; tick(); irq_ack = 0; endtask
   task automatic pulse_eoi(); eoi = 1; tick(); eoi = 0; endtask
   task automatic do_reset(); rst = 1; tick(2); rst = 0; endtask

   initial begin
      rst = 1; src_in = '0; edge_sel = 4'hF; ie = 4'hF; clr_pend = '0;
      gie = 1; irq_ack = 0; eoi = 0;
      tick(2);
      chk("reset irq_vec", int'(irq_vec), 'h010);
      chk("reset irq_id", int'(irq_id), 0);
      rst = 0;
      tick(2);

      // Single edge on source 2
      src_in = 4'b0100; tick();
      chk("single pending", int'(pending), 4'b0100);
      tick();
      chk("single vec", int'(irq_vec), 'h030);
      pulse_ack();
      chk("single in_service", int'(in_service), 4'b0100);
      pulse_eoi();
      src_in = '0; tick(2);

      // Simultaneous edges on sources 3 and 1
      src_in = 4'b1010; tick(2);
      chk("prio first vec", int'(irq_vec), 'h020);
      pulse_ack(); pulse_eoi(); tick();
      chk("prio second vec", int'(irq_vec), 'h040);
      pulse_ack(); pulse_eoi();
      src_in = '0; tick(2);

      // Level source 0: gie withdrawal, re-request, line drop
      edge_sel = 4'b1110; src_in = 4'b0001; tick(2);
      gie = 0; tick(2);
      gie = 1; tick(2);
      src_in = 4'b0000; tick(3);
      edge_sel = 4'hF; tick();

      // Overflow and set-wins-over-clear on source 1
      src_in = 4'b0010; tick();
      src_in = 4'b0000; tick();
      src_in = 4'b0010; tick();
      src_in = 4'b0000; tick();
      src_in = 4'b0010; clr_pend = 4'b0010; tick();
      clr_pend = '0;
      chk("set wins pending", int'(pending[1]), 1);
      pulse_ack(); pulse_eoi(); tick(2);

      // Reset while source 0 in service with source 3 requesting
      src_in = 4'b0001; tick(2); pulse_ack();
      src_in = 4'b1001; tick(3);
      do_reset();
      tick(3);
      src_in = '0; tick(2);

      // Source 2 in service, then edge on source 0
      src_in = 4'b0100; tick(2); pulse_ack();
      src_in = 4'b0101; tick(3);
      pulse_ack(); pulse_eoi(); tick(2); pulse_ack(); pulse_eoi(); pulse_eoi(); tick(2);
      src_in = '0; do_reset();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 5) == 0) src_in[i] = ~src_in[i];
         if ($urandom_range(0, 40) == 0) edge_sel = 4'($urandom);
         if ($urandom_range(0, 30) == 0) ie = 4'($urandom) | 4'b0001;
         gie      = ($urandom_range(0, 15) != 0);
         clr_pend = ($urandom_range(0, 8) == 0) ? 4'($urandom) : 4'b0000;
         irq_ack  = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 20) == 0);
         eoi      = (m_isr != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 20) == 0);
         rst      = ($urandom_range(0, 200) == 0);
         tick();
      end
      rst = 0; irq_ack = 0; eoi = 0; clr_pend = '0;
      tick(2);
      @(negedge clk); @(negedge clk);
      chk("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
